n1_dsp_mul_arb: RTL
===================

// Module: n1_dsp_mul_arb
// PURPOSE
//  Shares the single DSP-cell multiplier of the N1 DSP partition between two requesters
//  (port 0: ALU, port 1: coprocessor/debug client). Issues at most one multiply per cycle,
//  tracks ownership of every in-flight operation through the DSP pipeline and returns each
//  32-bit product to the requester that issued it. Sits between the requesters and the
//  multiplier operand/result pins of the DSP partition.
// PARAMETERS
//  MUL_LAT   2  cycles from operands-on-multiplier to valid mul_res_i (legal 1..4)
//  FIX_PRIO  0  1: port 0 always wins; 0: round-robin between ports
// PORTS
//  clk_i            in   1   module clock
//  async_rst_i      in   1   asynchronous reset, active high
//  req0_stb_i       in   1   port 0 multiply request
//  req0_sel_i       in   1   port 0 1:signed, 0:unsigned
//  req0_opd0_i      in   16  port 0 first operand
//  req0_opd1_i      in   16  port 0 second operand
//  req0_ack_o       out  1   port 0 request accepted this cycle
//  req0_rdy_o       out  1   port 0 result valid (1-cycle pulse)
//  req0_res_o       out  32  port 0 product (held until next port 0 result)
//  req1_*           -    -   identical set for port 1
//  mul_sel_o        out  1   to DSP: 1:signed, 0:unsigned
//  mul_opd0_o       out  16  to DSP: first operand
//  mul_opd1_o       out  16  to DSP: second operand
//  mul_res_i        in   32  from DSP: product, MUL_LAT cycles after operands
//  prb_arb_last_o   out  1   probe: last granted port
//  prb_arb_busy_o   out  1   probe: any operation in flight
// BEHAVIOUR
//  Reset (async_rst_i=1): all ack/rdy 0, req*_res_o 0, pipeline valid bits 0, last-grant
//   flag 1 (so port 0 wins first tie), prb outputs 0. Effective immediately, no clock needed.
//  Arbitration (combinational, same cycle):
//   - only stb0: grant 0; only stb1: grant 1; none: no grant.
//   - both, FIX_PRIO=1: grant 0. Both, FIX_PRIO=0: grant port != last-grant flag.
//   - last-grant flag updates on every grant; unchanged on idle cycles.
//   - reqN_ack_o = reqN_stb_i & grantN. Losing requester holds stb/operands until ack.
//  Operand mux: granted port's sel/opd0/opd1 drive mul_*_o; no grant -> all zero.
//  Tracking: shift register of MUL_LAT stages {valid, owner}; stage0 loaded with
//   {grant_any, grant_port} each cycle; shifts every cycle (no stall, DSP never back-pressures).
//  Return: when final stage valid, mul_res_i is registered into res of owner; that port's
//   rdy_o pulses high next cycle. Total latency ack -> rdy = MUL_LAT+1 cycles.
//   Other port's res_o unchanged. Back-to-back issues give back-to-back rdy pulses.
//  Throughput: one issue/cycle; both ports can have ops in flight concurrently; ordering
//   per port is preserved (single in-order pipeline).
//  Simultaneous: a new request may be acked in the same cycle a result returns.
//  Reset mid-operation: in-flight ops discarded, no rdy pulse ever emitted for them.
//  prb_arb_busy_o = OR of all pipeline valid bits (registered view).
//  Width rules: product width fixed 32; no truncation; sign handling is the DSP's.
// TESTING
//  Reset: assert async_rst_i mid-clock -> ack/rdy/res/prb all 0 without clock edge.
//  Single op: port0 stb, unsigned 0x00FF*0x0100 -> ack0 same cycle, rdy0 after 3
//   cycles (MUL_LAT=2), res0=0x0000FF00; rdy1 stays 0.
//  Contention RR: both stb every cycle for 4 cycles -> grants 0,1,0,1; rdy pulses
//   alternate 0,1,0,1 with matching products; losing port's operands unchanged until ack.
//  FIX_PRIO=1: both stb for 3 cycles -> only ack0; ack1 after stb0 drops.
//  Signed: port1 sel=1, 0xFFFF*0x0002 -> res1=0xFFFFFFFE; port0 res unchanged.
//  Reset flush: issue 2 ops, reset 1 cycle later -> no rdy pulses, busy=0 after reset.

Source files
------------

// File: rtl/n1_dsp_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : n1_dsp_mul_arb
// Function : Two-port arbiter for the shared N1 DSP multiplier with in-order
//            ownership tracking and per-port product return.
// Revision : 1.0
// ============================================================================
module n1_dsp_mul_arb #(
    parameter int MUL_LAT  = 2,
    parameter bit FIX_PRIO = 1'b0
) (
    input  logic        clk_i,
    input  logic        async_rst_i,
    input  logic        req0_stb_i,
    input  logic        req0_sel_i,
    input  logic [15:0] req0_opd0_i,
    input  logic [15:0] req0_opd1_i,
    output logic        req0_ack_o,
    output logic        req0_rdy_o,
    output logic [31:0] req0_res_o,
    input  logic        req1_stb_i,
    input  logic        req1_sel_i,
    input  logic [15:0] req1_opd0_i,
    input  logic [15:0] req1_opd1_i,
    output logic        req1_ack_o,
    output logic        req1_rdy_o,
    output logic [31:0] req1_res_o,
    output logic        mul_sel_o,
    output logic [15:0] mul_opd0_o,
    output logic [15:0] mul_opd1_o,
    input  logic [31:0] mul_res_i,
    output logic        prb_arb_last_o,
    output logic        prb_arb_busy_o
);

    localparam int LAST_STG = MUL_LAT - 1;

    logic               last_q, last_d;
    logic               prb_last_q, prb_last_d;
    logic [MUL_LAT-1:0] vld_q, vld_d;
    logic [MUL_LAT-1:0] own_q, own_d;
    logic               rdy0_q, rdy0_d;
    logic               rdy1_q, rdy1_d;
    logic [31:0]        res0_q, res0_d;
    logic [31:0]        res1_q, res1_d;

    logic               w_grant_any;
    logic               w_grant_port;
    logic               w_ret_vld;
    logic               w_ret_own;

    // Grants are masked while reset is held so ack drops without a clock edge.
    always_comb begin
        w_grant_any  = 1'b0;
        w_grant_port = 1'b0;
        if (!async_rst_i) begin
            if (req0_stb_i && req1_stb_i) begin
                w_grant_any  = 1'b1;
                w_grant_port = FIX_PRIO ? 1'b0 : ~last_q;
            end else if (req0_stb_i) begin
                w_grant_any  = 1'b1;
                w_grant_port = 1'b0;
            end else if (req1_stb_i) begin
                w_grant_any  = 1'b1;
                w_grant_port = 1'b1;
            end
        end
    end

    assign req0_ack_o = req0_stb_i & w_grant_any & ~w_grant_port;
    assign req1_ack_o = req1_stb_i & w_grant_any &  w_grant_port;

    always_comb begin
        mul_sel_o  = 1'b0;
        mul_opd0_o = 16'h0000;
        mul_opd1_o = 16'h0000;
        if (w_grant_any) begin
            if (w_grant_port) begin
                mul_sel_o  = req1_sel_i;
                mul_opd0_o = req1_opd0_i;
                mul_opd1_o = req1_opd1_i;
            end else begin
                mul_sel_o  = req0_sel_i;
                mul_opd0_o = req0_opd0_i;
                mul_opd1_o = req0_opd1_i;
            end
        end
    end

    // Ownership shift register mirrors the DSP pipeline; it never stalls.
    always_comb begin
        vld_d    = vld_q;
        own_d    = own_q;
        vld_d[0] = w_grant_any;
        own_d[0] = w_grant_port;
        for (int i = 1; i < MUL_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    assign w_ret_vld = vld_q[LAST_STG];
    assign w_ret_own = own_q[LAST_STG];

    always_comb begin
        last_d     = w_grant_any ? w_grant_port : last_q;
        prb_last_d = w_grant_any ? w_grant_port : prb_last_q;
        rdy0_d     = w_ret_vld & ~w_ret_own;
        rdy1_d     = w_ret_vld &  w_ret_own;
        res0_d     = rdy0_d ? mul_res_i : res0_q;
        res1_d     = rdy1_d ? mul_res_i : res1_q;
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            last_q     <= 1'b1;
            prb_last_q <= 1'b0;
            vld_q      <= '0;
            own_q      <= '0;
            rdy0_q     <= 1'b0;
            rdy1_q     <= 1'b0;
            res0_q     <= 32'h0000_0000;
            res1_q     <= 32'h0000_0000;
        end else begin
            last_q     <= last_d;
            prb_last_q <= prb_last_d;
            vld_q      <= vld_d;
            own_q      <= own_d;
            rdy0_q     <= rdy0_d;
            rdy1_q     <= rdy1_d;
            res0_q     <= res0_d;
            res1_q     <= res1_d;
        end
    end

    assign req0_rdy_o     = rdy0_q;
    assign req1_rdy_o     = rdy1_q;
    assign req0_res_o     = res0_q;
    assign req1_res_o     = res1_q;
    assign prb_arb_last_o = prb_last_q;
    assign prb_arb_busy_o = |vld_q;

endmodule
`default_nettype wire
